// File: rtl/pe_feeder.sv
// Memory-side feeder for a single PE: loads K filter taps, streams ifmap samples
// paired with the matching weight, and collects returned partial sums in a result FIFO.
module pe_feeder #(
    parameter int DATA_WIDTH = 16,
    parameter int MAX_K      = 7,
    parameter int RES_DEPTH  = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cfg_start,
    input  logic [2:0]                cfg_kernel_size,
    input  logic [15:0]               cfg_num_out,
    input  logic                      w_valid,
    output logic                      w_ready,
    input  logic [DATA_WIDTH-1:0]     w_data,
    input  logic                      x_valid,
    output logic                      x_ready,
    input  logic [DATA_WIDTH-1:0]     x_data,
    output logic                      pe_ready,
    output logic [DATA_WIDTH-1:0]     pe_ifmap,
    output logic [DATA_WIDTH-1:0]     pe_fltr,
    output logic [2*DATA_WIDTH-1:0]   pe_psum,
    output logic [2:0]                pe_kernel_size,
    input  logic                      pe_valid,
    input  logic [2*DATA_WIDTH-1:0]   pe_psum_in,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic [2*DATA_WIDTH-1:0]   res_data,
    output logic                      busy,
    output logic                      done,
    output logic                      err
);

    localparam int PW = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;
    localparam int CW = $clog2(RES_DEPTH + 1);

    typedef enum logic [1:0] {IDLE, LOAD_W, STREAM, DRAIN} state_t;

    state_t                  state;
    logic [DATA_WIDTH-1:0]   weight [MAX_K];
    logic [2*DATA_WIDTH-1:0] fifo_mem [RES_DEPTH];
    logic [PW-1:0]           wr_ptr;
    logic [PW-1:0]           rd_ptr;
    logic [CW-1:0]           fifo_count;
    logic [2:0]              k_reg;
    logic [2:0]              idx;
    logic [2:0]              tap;
    logic [15:0]             num_out;
    logic [15:0]             issued;
    logic [15:0]             outstanding;
    logic [15:0]             collected;

    logic w_beat, x_beat, fifo_pop, fifo_full, tap_wrap;
    logic psum_accept, psum_reject, cfg_ok;

    // x_ready reserves a FIFO slot for every sum still in flight so a returning
    // result can never find the FIFO full.
    assign w_ready  = (state == LOAD_W);
    assign x_ready  = (state == STREAM) && (issued != num_out) &&
                      (({1'b0, outstanding} + 17'(fifo_count)) < 17'(RES_DEPTH));
    assign busy     = (state != IDLE);
    assign pe_psum  = '0;
    assign pe_kernel_size = (state == IDLE) ? 3'd0 : k_reg;
    assign res_valid = (fifo_count != '0);
    assign res_data  = res_valid ? fifo_mem[rd_ptr] : '0;

    assign w_beat    = w_valid & w_ready;
    assign x_beat    = x_valid & x_ready;
    assign fifo_pop  = res_valid & res_ready;
    assign fifo_full = (fifo_count == CW'(RES_DEPTH));
    assign tap_wrap  = x_beat && (tap == k_reg - 3'd1);
    assign cfg_ok    = (cfg_kernel_size != 3'd0) && (cfg_kernel_size <= 3'(MAX_K)) &&
                       (cfg_num_out != 16'd0);
    // A pop in the same cycle frees the slot the push needs.
    assign psum_accept = pe_valid && (outstanding != 16'd0) && (!fifo_full || fifo_pop);
    assign psum_reject = pe_valid && !psum_accept;

    always_ff @(posedge clk) begin
        if (!rst && w_beat)      weight[idx]      <= w_data;
        if (!rst && psum_accept) fifo_mem[wr_ptr] <= pe_psum_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_count  <= '0;
            k_reg       <= '0;
            idx         <= '0;
            tap         <= '0;
            num_out     <= '0;
            issued      <= '0;
            outstanding <= '0;
            collected   <= '0;
            pe_ready    <= 1'b0;
            pe_ifmap    <= '0;
            pe_fltr     <= '0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            done     <= 1'b0;
            pe_ready <= 1'b0;
            if (psum_reject) err <= 1'b1;

            if (psum_accept) begin
                wr_ptr    <= (wr_ptr == PW'(RES_DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
                collected <= collected + 16'd1;
            end
            if (fifo_pop) rd_ptr <= (rd_ptr == PW'(RES_DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
            case ({psum_accept, fifo_pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
            case ({tap_wrap, psum_accept})
                2'b10:   outstanding <= outstanding + 16'd1;
                2'b01:   outstanding <= outstanding - 16'd1;
                default: outstanding <= outstanding;
            endcase

            unique case (state)
                IDLE: begin
                    if (cfg_start && cfg_ok) begin
                        k_reg     <= cfg_kernel_size;
                        num_out   <= cfg_num_out;
                        idx       <= '0;
                        tap       <= '0;
                        issued    <= '0;
                        collected <= '0;
                        state     <= LOAD_W;
                    end
                end
                LOAD_W: begin
                    if (w_beat) begin
                        idx <= idx + 3'd1;
                        if (idx == k_reg - 3'd1) state <= STREAM;
                    end
                end
                STREAM: begin
                    if (x_beat) begin
                        pe_ready <= 1'b1;
                        pe_ifmap <= x_data;
                        pe_fltr  <= weight[tap];
                        if (tap_wrap) begin
                            tap    <= '0;
                            issued <= issued + 16'd1;
                            if (issued + 16'd1 == num_out) state <= DRAIN;
                        end else begin
                            tap <= tap + 3'd1;
                        end
                    end
                end
                DRAIN: begin
                    if ((collected == num_out) && (fifo_count == '0)) begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pe_feeder.sv
// Directed bench for pe_feeder: a behavioural PE returns each K-tap dot product after
// a programmable latency; results, filter taps and done pulses are checked against hand values.
module tb_pe_feeder;
    localparam int DW = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            cfg_start = 1'b0;
    logic [2:0]      cfg_kernel_size = '0;
    logic [15:0]     cfg_num_out = '0;
    logic            w_valid = 1'b0;
    logic            w_ready;
    logic [DW-1:0]   w_data = '0;
    logic            x_valid = 1'b0;
    logic            x_ready;
    logic [DW-1:0]   x_data = '0;
    logic            pe_ready;
    logic [DW-1:0]   pe_ifmap;
    logic [DW-1:0]   pe_fltr;
    logic [2*DW-1:0] pe_psum;
    logic [2:0]      pe_kernel_size;
    logic            pe_valid;
    logic [2*DW-1:0] pe_psum_in;
    logic            res_valid;
    logic            res_ready;
    logic [2*DW-1:0] res_data;
    logic            busy;
    logic            done;
    logic            err;

    always #5 clk = ~clk;

    pe_feeder #(.DATA_WIDTH(DW), .MAX_K(7), .RES_DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .cfg_start(cfg_start), .cfg_kernel_size(cfg_kernel_size), .cfg_num_out(cfg_num_out),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
        .x_valid(x_valid), .x_ready(x_ready), .x_data(x_data),
        .pe_ready(pe_ready), .pe_ifmap(pe_ifmap), .pe_fltr(pe_fltr), .pe_psum(pe_psum),
        .pe_kernel_size(pe_kernel_size), .pe_valid(pe_valid), .pe_psum_in(pe_psum_in),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .busy(busy), .done(done), .err(err)
    );

    // PE model and result-ready pattern
    int          model_k   = 1;
    int          model_lat = 4;
    logic        model_v   = 1'b0;
    logic [31:0] model_d   = '0;
    logic        spur_v    = 1'b0;
    logic [31:0] spur_d    = '0;
    logic        rr_toggle = 1'b0;
    logic        rr_phase  = 1'b0;
    logic        rr_fixed  = 1'b0;
    bit          pv [8];
    logic [31:0] pd [8];
    logic [31:0] acc = '0;
    int          cnt = 0;

    assign pe_valid   = model_v | spur_v;
    assign pe_psum_in = spur_v ? spur_d : model_d;
    assign res_ready  = rr_toggle ? rr_phase : rr_fixed;

    always @(negedge clk) begin
        for (int i = 7; i > 0; i--) begin
            pv[i] = pv[i-1];
            pd[i] = pd[i-1];
        end
        pv[0] = 1'b0;
        pd[0] = '0;
        if (rst) begin
            acc = '0;
            cnt = 0;
            for (int i = 0; i < 8; i++) pv[i] = 1'b0;
        end else if (pe_ready) begin
            acc = acc + 32'(pe_ifmap) * 32'(pe_fltr);
            cnt++;
            if (cnt == model_k) begin
                pv[0] = 1'b1;
                pd[0] = acc;
                acc = '0;
                cnt = 0;
            end
        end
        #1;
        model_v  = pv[model_lat-1];
        model_d  = pd[model_lat-1];
        rr_phase = ~rr_phase;
    end

    // Monitor: samples after all drivers settle, before the next rising edge
    logic [31:0] got [$];
    logic [31:0] fltr_q [$];
    int          done_cnt = 0;

    always @(negedge clk) begin
        #3;
        if (res_valid && res_ready) got.push_back(res_data);
        if (pe_ready) fltr_q.push_back(32'(pe_fltr));
        if (done) done_cnt++;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        #2;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_flags"}, {25'b0, w_ready, x_ready, pe_ready, res_valid, busy, done, err}, 32'h0);
        check({tag, "_ifmap"}, 32'(pe_ifmap), 32'h0);
        check({tag, "_fltr"}, 32'(pe_fltr), 32'h0);
        check({tag, "_psum"}, pe_psum, 32'h0);
        check({tag, "_ksize"}, 32'(pe_kernel_size), 32'h0);
        check({tag, "_rdata"}, res_data, 32'h0);
    endtask

    task automatic start_job(input int k, input int n);
        cfg_kernel_size = 3'(k);
        cfg_num_out     = 16'(n);
        cfg_start       = 1'b1;
        cyc();
        cfg_start = 1'b0;
    endtask

    logic [DW-1:0] wts [8];

    task automatic load_w(input int n);
        int t;
        logic tmo;
        tmo = 1'b0;
        for (int i = 0; i < n; i++) begin
            w_valid = 1'b1;
            w_data  = wts[i];
            t = 0;
            while (!w_ready && t < 50) begin
                cyc();
                t++;
            end
            if (t >= 50) tmo = 1'b1;
            cyc();
        end
        w_valid = 1'b0;
        check("w_timeout", 32'(tmo), 32'h0);
    endtask

    task automatic stream_x(input int n, input int first, input int budget, output int sent);
        int t;
        sent = 0;
        t = 0;
        x_valid = 1'b1;
        x_data  = DW'(first);
        while (sent < n && t < budget) begin
            if (x_ready) begin
                cyc();
                sent++;
                x_data = DW'(first + sent);
            end else begin
                cyc();
            end
            t++;
        end
        x_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int base, input int budget);
        int t;
        t = 0;
        while (done_cnt == base && t < budget) begin
            cyc();
            t++;
        end
        check({tag, "_done_seen"}, 32'(done_cnt != base), 32'h1);
        cyc();
        cyc();
        check({tag, "_done_once"}, 32'(done_cnt - base), 32'h1);
        check({tag, "_busy_after"}, 32'(busy), 32'h0);
    endtask

    task automatic check_results(input string tag, input int base, input int n, input int first, input int step);
        check({tag, "_nres"}, 32'(got.size() - base), 32'(n));
        for (int i = 0; i < n; i++)
            check($sformatf("%s_res%0d", tag, i),
                  (base + i < got.size()) ? got[base + i] : 32'hFFFF_FFFF, 32'(first + step * i));
    endtask

    logic [31:0] exp_fltr [6] = '{1, 2, 3, 1, 2, 3};

    initial begin
        int sent, gbase, fbase, dbase;

        repeat (3) cyc();
        check_reset_outputs("reset");
        rst = 1'b0;
        cyc();

        // Illegal configurations are ignored
        start_job(0, 5);
        cyc();
        check("k0_idle", {30'b0, busy, w_ready}, 32'h0);
        start_job(3, 0);
        cyc();
        check("n0_idle", {30'b0, busy, w_ready}, 32'h0);
        check("n0_ksize", 32'(pe_kernel_size), 32'h0);

        // K=3, two outputs: sums 4+10+18=32, 7+16+27=50
        rr_fixed = 1'b1;
        model_k = 3;
        gbase = got.size();
        fbase = fltr_q.size();
        dbase = done_cnt;
        start_job(3, 2);
        check("k3_busy_wready", {30'b0, busy, w_ready}, 32'h3);
        check("k3_ksize", 32'(pe_kernel_size), 32'h3);
        wts[0] = 16'd1; wts[1] = 16'd2; wts[2] = 16'd3;
        load_w(3);
        stream_x(6, 4, 40, sent);
        check("k3_sent", 32'(sent), 32'h6);
        wait_done("k3", dbase, 60);
        check("k3_nfltr", 32'(fltr_q.size() - fbase), 32'h6);
        for (int i = 0; i < 6; i++)
            check($sformatf("k3_fltr%0d", i),
                  (fbase + i < fltr_q.size()) ? fltr_q[fbase + i] : 32'hFFFF_FFFF, exp_fltr[i]);
        check_results("k3", gbase, 2, 32, 18);
        check("k3_err", 32'(err), 32'h0);

        // K=1, six outputs with results held back: issue stalls after four
        rr_fixed = 1'b0;
        model_k = 1;
        gbase = got.size();
        dbase = done_cnt;
        start_job(1, 6);
        wts[0] = 16'd2;
        load_w(1);
        stream_x(6, 1, 14, sent);
        check("k1_sent_stalled", 32'(sent), 32'h4);
        check("k1_xready_low", 32'(x_ready), 32'h0);
        check("k1_res_valid", 32'(res_valid), 32'h1);
        check("k1_res_head", res_data, 32'h2);
        repeat (3) cyc();
        check("k1_res_hold", res_data, 32'h2);
        check("k1_no_pop", 32'(got.size() - gbase), 32'h0);
        rr_fixed = 1'b1;
        stream_x(2, 5, 60, sent);
        check("k1_sent_rest", 32'(sent), 32'h2);
        wait_done("k1", dbase, 60);
        check_results("k1", gbase, 6, 2, 2);
        check("k1_err", 32'(err), 32'h0);

        // K=2 with alternating res_ready at two PE latencies so returns land on
        // both tap-wrap and non-wrap cycles: sums 6i+5
        model_k = 2;
        rr_toggle = 1'b1;
        for (int lat = 4; lat <= 5; lat++) begin
            model_lat = lat;
            gbase = got.size();
            dbase = done_cnt;
            start_job(2, 8);
            wts[0] = 16'd1; wts[1] = 16'd2;
            load_w(2);
            stream_x(16, 1, 200, sent);
            check($sformatf("coin%0d_sent", lat), 32'(sent), 32'd16);
            wait_done($sformatf("coin%0d", lat), dbase, 100);
            check_results($sformatf("coin%0d", lat), gbase, 8, 5, 6);
            check($sformatf("coin%0d_err", lat), 32'(err), 32'h0);
        end
        rr_toggle = 1'b0;
        model_lat = 4;

        // Spurious PE result in IDLE is dropped and flagged until reset
        spur_d = 32'h0000_DEAD;
        spur_v = 1'b1;
        cyc();
        spur_v = 1'b0;
        cyc();
        check("spur_err", 32'(err), 32'h1);
        check("spur_res_valid", 32'(res_valid), 32'h0);
        repeat (4) cyc();
        check("spur_err_sticky", 32'(err), 32'h1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        cyc();
        check("spur_err_cleared", 32'(err), 32'h0);

        // Abort in STREAM after 5 beats, then a clean K=2 job: 3+8=11, 9+16=25, 15+24=39
        model_k = 3;
        start_job(3, 4);
        wts[0] = 16'd1; wts[1] = 16'd1; wts[2] = 16'd1;
        load_w(3);
        stream_x(5, 1, 40, sent);
        check("abort_sent", 32'(sent), 32'h5);
        check("abort_busy", 32'(busy), 32'h1);
        rst = 1'b1;
        cyc();
        check_reset_outputs("abort");
        cyc();
        rst = 1'b0;
        cyc();
        model_k = 2;
        gbase = got.size();
        dbase = done_cnt;
        start_job(2, 3);
        check("rerun_ksize", 32'(pe_kernel_size), 32'h2);
        wts[0] = 16'd3; wts[1] = 16'd4;
        load_w(2);
        stream_x(6, 1, 60, sent);
        check("rerun_sent", 32'(sent), 32'h6);
        wait_done("rerun", dbase, 60);
        check_results("rerun", gbase, 3, 11, 14);
        check("rerun_err", 32'(err), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
